sipo_frame_rx: RTL
==================

# sipo_frame_rx

Serial-in, parallel-out frame receiver: the receive end of the 10-bit serial frames our parallel-to-serial shifter produces. Each frame is one start bit (0), DATA_BITS data bits LSB first, and one stop bit (1); the line idles high. The block hunts for a start bit and samples each bit at its mid-point. It presents the assembled word with a one-cycle valid strobe and flags frames whose stop bit is bad. It sits on the same clock as the transmitter; serial_in is synchronous to clk, so the block has no input synchronizer.

## Interface
- DATA_BITS, 8, number of data bits per frame (1..16)
- CLKS_PER_BIT, 1, clk cycles per serial bit (≥1); 1 matches the shifter's one-bit-per-clock rate
- clk  input  1  clock; all sampling on rising edge
- reset  input  1  asynchronous, active-high
- serial_in  input  1  serial line, idle high
- data_out  output  DATA_BITS  last correctly framed word; holds until the next good frame
- data_valid  output  1  one-cycle strobe: data_out updated this cycle
- frame_err  output  1  one-cycle strobe: stop bit sampled 0
- busy  output  1  high while a frame is in progress (START, DATA, STOP)

## Operation
- States:
  - WAIT_IDLE: entered from reset and after a framing error. Go to IDLE on the first edge that samples serial_in=1. This means a line held low (including the shifter's all-zero reset state) is never taken as a start bit.
  - IDLE: on an edge sampling serial_in=0 (call it t0), clear the bit counters and go to START. When CLKS_PER_BIT=1, the t0 sample itself is the start-bit check and the block goes directly to DATA.
  - START: wait H=(CLKS_PER_BIT-1)/2 (integer) cycles, then re-sample at t0+H. If 0, go to DATA. If 1, it is a false start: go to IDLE with no strobe.
  - DATA: sample data bit k (k=0..DATA_BITS-1) at edge t0+H+(k+1)·CLKS_PER_BIT. Shift right, new bit into the MSB, so bit 0 ends at data_out[0].
  - STOP: sample at t0+H+(DATA_BITS+1)·CLKS_PER_BIT.
    - If 1: load the shift register into data_out, pulse data_valid, go to IDLE.
    - If 0: pulse frame_err, leave data_out unchanged, go to WAIT_IDLE.
- data_valid and frame_err are mutually exclusive and are never high two cycles in a row from the same frame.
- Counters:
  - Cycle counter width is ceil(log2(CLKS_PER_BIT))+1.
  - Bit counter width is ceil(log2(DATA_BITS+1)).
  - Neither counter wraps within a frame.
- Reset (any time, including mid-frame):
  - Immediately: data_out=0, data_valid=0, frame_err=0, busy=0, shift register=0, state=WAIT_IDLE.
  - Any partial frame is discarded.
- Back-to-back frames: after a good stop sample the block is in IDLE. A start bit sampled on the very next edge must be accepted; no idle gap is required.

## Timing
- Reset values: data_out=0, data_valid=0, frame_err=0, busy=0.
- data_out, data_valid and frame_err are all registered. They change on the stop-sample edge, so they are visible in the cycle right after that edge.
- busy rises on the t0 edge (CLKS_PER_BIT>1) or the t0 edge (=1, DATA directly). It falls on the stop-sample edge.
- Latency for CLKS_PER_BIT=1, DATA_BITS=8:
  - start at edge t0, data at edges t0+1..t0+8, stop at t0+9
  - data_valid high for the cycle following edge t0+9
- Latency for CLKS_PER_BIT=4: H=1, start check at t0+1, data bit k at t0+5+4k, stop at t0+37.
- Frame period is (DATA_BITS+2)·CLKS_PER_BIT cycles. Sustained throughput is one word per frame period with no dead cycles.

## Test plan
- Reset hold, line low: assert reset, release with serial_in=0 for 5 cycles, then 1 -> no data_valid, no frame_err, busy=0 throughout; a following frame is received normally.
- Single frame (CLKS_PER_BIT=1): drive 0,1,0,1,0,0,1,0,1,1 on edges t0..t0+9 -> data_valid for exactly one cycle after t0+9 with data_out=0xA5; busy high from t0 to t0+9.
- Back-to-back: frames 0x00 and 0xFF with no idle bit between them -> two data_valid strobes 10 cycles apart, data_out 0x00 then 0xFF, frame_err stays 0.
- Framing error: frame 0x5A with stop bit 0, then the line stays low for 3 cycles -> frame_err one-cycle pulse, data_out keeps its prior value, no data_valid; start bits are ignored until serial_in has been sampled 1; the next frame (0x81) is received correctly.
- False start (CLKS_PER_BIT=4): one-cycle low glitch in IDLE -> return to IDLE, no strobes. A following 0x3C frame, held 4 cycles per bit, gives data_valid after edge t0+37 with data_out=0x3C.
- Reset mid-frame: assert reset during data bit 4 of a frame -> all outputs 0 immediately, no strobe; after release and an idle-high line, the next frame 0xC3 is received correctly.

Source files
------------

// File: rtl/sipo_frame_rx_if.sv
// Serial receive bus: the line in, the assembled word and its strobes out.
// master = line driver / word consumer, slave = the receiver.
interface sipo_frame_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 serial_in;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 frame_err;
  logic                 busy;

  modport master (
    output serial_in,
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  serial_in,
    output data_out,
    output data_valid,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/sipo_frame_rx.sv
// Start/data/stop frame receiver: mid-bit sampling, LSB-first, registered word with
// one-cycle data_valid / frame_err strobes; no flow control, one word per frame period.
module sipo_frame_rx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic          clk,
  input  logic          reset,
  sipo_frame_rx_if.slave rx
);

  localparam int H  = (CLKS_PER_BIT - 1) / 2;
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_HALF = CW'((H > 0) ? (H - 1) : 0);
  localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cyc_q, cyc_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_WAIT_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      S_WAIT_IDLE: begin
        if (rx.serial_in) state_d = S_IDLE;
      end

      S_IDLE: begin
        if (!rx.serial_in) begin
          cyc_d = '0;
          bit_d = '0;
          // With no half-bit wait the start-edge sample is itself the start check.
          state_d = (H == 0) ? S_DATA : S_START;
        end
      end

      S_START: begin
        if (cyc_q == CNT_HALF) begin
          cyc_d   = '0;
          state_d = rx.serial_in ? S_IDLE : S_DATA;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end

      S_DATA: begin
        if (cyc_q == CNT_BIT) begin
          cyc_d   = '0;
          shift_d = DATA_BITS'({rx.serial_in, shift_q} >> 1);
          bit_d   = bit_q + BW'(1);
          if (bit_q == BIT_LAST) state_d = S_STOP;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end

      S_STOP: begin
        if (cyc_q == CNT_BIT) begin
          cyc_d = '0;
          if (rx.serial_in) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end

      default: state_d = S_WAIT_IDLE;
    endcase
  end

  assign rx.data_out   = data_q;
  assign rx.data_valid = valid_q;
  assign rx.frame_err  = err_q;
  assign rx.busy       = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);

endmodule
